// File: rtl/clk_div_sched_pkg.sv
// Shared types and default parameter values for the clock-enable scheduler.
package clk_div_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } st_e;

   localparam int NCH_DEF   = 3;
   localparam int DIV_W_DEF = 8;

endpackage

// File: rtl/clk_div_sched_if.sv
// Configuration write bus: a request/ready handshake carrying channel and ratio.
interface clk_div_sched_if
   import clk_div_sched_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) ();

   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_ch;
   logic [DIV_W-1:0] cfg_div;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      output cfg_ready
   );

endinterface

// File: rtl/clk_div_chan.sv
// One divided channel: ratio register, phase counter, enable pulse, square wave
// and the parked flag used to end a run on a full-period boundary.
module clk_div_chan
   import clk_div_sched_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [DIV_W-1:0] wdata,
   input  logic             align,
   input  logic             run,
   input  logic             drain,
   output logic             ch_en,
   output logic             div_clk,
   output logic             parked
);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] cnt;
   logic             dclk;
   logic             park_q;
   logic             en;
   logic             at_zero;
   logic             park_now;
   logic             active;

   // dclk is the level before this cycle's toggle, so the visible wave changes
   // in the same cycle as the enable pulse rather than one cycle later.
   always_comb begin
      en       = (div != '0);
      at_zero  = (cnt == '0);
      park_now = drain && (!en || (at_zero && !dclk));
      active   = en && (run || (drain && !park_q && !park_now));
      ch_en    = active && at_zero;
      div_clk  = en && (dclk ^ ch_en);
      parked   = park_q || park_now;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div    <= '0;
         cnt    <= '0;
         dclk   <= 1'b0;
         park_q <= 1'b0;
      end else begin
         if (wr)
            div <= wdata;
         if (align) begin
            cnt    <= '0;
            dclk   <= 1'b0;
            park_q <= 1'b0;
         end else if (active) begin
            cnt  <= (cnt == div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
            dclk <= dclk ^ at_zero;
         end
         if (park_now)
            park_q <= 1'b1;
      end
   end

endmodule

// File: rtl/clk_div_sched.sv
// Programmable clock-enable scheduler: sequences NCH phase-aligned divided
// channels through IDLE/ALIGN/RUN/DRAIN and owns the configuration decode.
module clk_div_sched
   import clk_div_sched_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   clk_div_sched_if.slave cfg,
   input  logic           start,
   input  logic           stop,
   output logic           busy,
   output logic [NCH-1:0] ch_en,
   output logic [NCH-1:0] div_clk
);

   st_e            state;
   st_e            state_nx;
   logic           ready;
   logic           wr_any;
   logic           align_s;
   logic           run_s;
   logic           drain_s;
   logic [NCH-1:0] parked;
   logic           all_parked;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = ALIGN;
         ALIGN:   state_nx = stop ? DRAIN : RUN;
         RUN:     if (stop) state_nx = DRAIN;
         DRAIN:   if (all_parked) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ready   = (state == IDLE);
      busy    = (state != IDLE);
      align_s = (state == ALIGN);
      run_s   = (state == RUN);
      drain_s = (state == DRAIN);
      wr_any  = cfg.cfg_valid && ready;
   end

   assign cfg.cfg_ready = ready;
   assign all_parked    = &parked;

   // Writes addressed past the last channel match no instance and are dropped.
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      clk_div_chan #(
         .DIV_W (DIV_W)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .wr      (wr_any && (cfg.cfg_ch == 2'(i))),
         .wdata   (cfg.cfg_div),
         .align   (align_s),
         .run     (run_s),
         .drain   (drain_s),
         .ch_en   (ch_en[i]),
         .div_clk (div_clk[i]),
         .parked  (parked[i])
      );
   end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: cycle-by-cycle vector table plus
// hand-written async-reset and maximum-ratio sequences.
module tb_clk_div_sched;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       busy;
   logic [2:0] ch_en;
   logic [2:0] div_clk;

   int tests = 0;
   int fails = 0;

   clk_div_sched_if #(.DIV_W(8)) cfg_bus ();

   clk_div_sched #(
      .NCH   (3),
      .DIV_W (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .cfg     (cfg_bus),
      .start   (start),
      .stop    (stop),
      .busy    (busy),
      .ch_en   (ch_en),
      .div_clk (div_clk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [1:0] ch;
      logic [7:0] d;
      logic       st;
      logic       sp;
      logic [2:0] en;
      logic [2:0] ck;
      logic       bz;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic v, input logic [1:0] ch, input logic [7:0] d,
                               input logic st, input logic sp,
                               input logic [2:0] en, input logic [2:0] ck, input logic bz);
      vec_t e;
      e.v = v; e.ch = ch; e.d = d; e.st = st; e.sp = sp;
      e.en = en; e.ck = ck; e.bz = bz;
      vq.push_back(e);
   endfunction

   // Idle cycle carrying a config write.
   function automatic void w(input logic [1:0] ch, input logic [7:0] d);
      add(1'b1, ch, d, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
   endfunction

   // Busy cycle with optional start/stop pulses.
   function automatic void r(input logic st, input logic sp, input logic [2:0] en, input logic [2:0] ck);
      add(1'b0, 2'd0, 8'd0, st, sp, en, ck, 1'b1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_ch    = 2'd0;
      cfg_bus.cfg_div   = 8'd0;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      rst = 1'b0;
      idle_inputs();

      // Divide chain 1/2/4, then stop with all three draining at different points.
      w(2'd0, 8'd1); w(2'd1, 8'd2); w(2'd2, 8'd4);
      add(1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
      r(0, 0, 3'b000, 3'b000);
      r(0, 0, 3'b111, 3'b111);
      r(0, 0, 3'b001, 3'b110);
      r(0, 0, 3'b011, 3'b101);
      r(0, 0, 3'b001, 3'b100);
      r(0, 0, 3'b111, 3'b011);
      r(0, 0, 3'b001, 3'b010);
      r(0, 0, 3'b011, 3'b001);
      r(0, 0, 3'b001, 3'b000);
      r(0, 1, 3'b111, 3'b111);
      r(0, 0, 3'b001, 3'b110);
      r(0, 0, 3'b010, 3'b100);
      r(0, 0, 3'b000, 3'b100);
      r(0, 0, 3'b100, 3'b000);
      for (int i = 0; i < 4; i++) r(0, 0, 3'b000, 3'b000);
      // Clean stop on a single d=4 channel; write and start share a cycle.
      w(2'd1, 8'd0); w(2'd2, 8'd0); w(2'd3, 8'd5);
      add(1'b1, 2'd0, 8'd4, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
      r(0, 0, 3'b000, 3'b000);
      r(0, 0, 3'b001, 3'b001);
      r(0, 0, 3'b000, 3'b001);
      r(0, 0, 3'b000, 3'b001);
      r(0, 1, 3'b000, 3'b001);
      r(0, 0, 3'b001, 3'b000);
      for (int i = 0; i < 4; i++) r(0, 0, 3'b000, 3'b000);
      // Disabled middle channel plus a discarded write to channel 3.
      w(2'd0, 8'd2); w(2'd2, 8'd3);
      add(1'b1, 2'd3, 8'd7, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
      r(0, 0, 3'b000, 3'b000);
      r(0, 0, 3'b101, 3'b101);
      r(0, 0, 3'b000, 3'b101);
      r(0, 0, 3'b001, 3'b100);
      r(0, 0, 3'b100, 3'b000);
      r(0, 1, 3'b001, 3'b001);
      r(0, 0, 3'b000, 3'b001);
      r(0, 0, 3'b001, 3'b000);
      r(0, 0, 3'b000, 3'b000);
      r(0, 0, 3'b000, 3'b000);
      // Stop during ALIGN.
      add(1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
      r(0, 1, 3'b000, 3'b000);
      r(0, 0, 3'b000, 3'b000);
      // Config lockout while running; start and second stop ignored in DRAIN.
      add(1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
      r(0, 0, 3'b000, 3'b000);
      add(1'b1, 2'd0, 8'd5, 1'b0, 1'b0, 3'b101, 3'b101, 1'b1);
      add(1'b1, 2'd0, 8'd5, 1'b0, 1'b0, 3'b000, 3'b101, 1'b1);
      r(0, 1, 3'b001, 3'b100);
      r(0, 0, 3'b100, 3'b000);
      r(1, 0, 3'b000, 3'b000);
      r(0, 1, 3'b000, 3'b000);
      r(0, 0, 3'b000, 3'b000);
      w(2'd0, 8'd5);
      add(1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
      r(0, 0, 3'b000, 3'b000);
      r(0, 0, 3'b101, 3'b101);
      r(0, 0, 3'b000, 3'b101);
      r(0, 0, 3'b000, 3'b101);
      r(0, 0, 3'b100, 3'b001);
      r(0, 0, 3'b000, 3'b001);
      r(0, 1, 3'b001, 3'b000);
      for (int i = 0; i < 5; i++) r(0, 0, 3'b000, 3'b000);
      add(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset ch_en", 32'(ch_en), 32'd0);
      chk("reset div_clk", 32'(div_clk), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
      rst = 1'b1;
      tick();

      foreach (vq[k]) begin
         cfg_bus.cfg_valid = vq[k].v;
         cfg_bus.cfg_ch    = vq[k].ch;
         cfg_bus.cfg_div   = vq[k].d;
         start = vq[k].st;
         stop  = vq[k].sp;
         chk($sformatf("vec%0d ch_en", k), 32'(ch_en), 32'(vq[k].en));
         chk($sformatf("vec%0d div_clk", k), 32'(div_clk), 32'(vq[k].ck));
         chk($sformatf("vec%0d busy", k), 32'(busy), 32'(vq[k].bz));
         chk($sformatf("vec%0d cfg_ready", k), 32'(cfg_bus.cfg_ready), 32'(!vq[k].bz));
         tick();
      end
      idle_inputs();

      // Asynchronous reset with channel 0 (d=5) high mid-run.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("pre-reset div_clk", 32'(div_clk), 32'b101);
      #2;
      rst = 1'b0;
      #1;
      chk("async ch_en", 32'(ch_en), 32'd0);
      chk("async div_clk", 32'(div_clk), 32'd0);
      chk("async busy", 32'(busy), 32'd0);
      chk("async cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
      tick();
      rst = 1'b1;
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_ch    = 2'd0;
      cfg_bus.cfg_div   = 8'd2;
      start = 1'b1;
      tick();
      idle_inputs();
      chk("post-reset align ch_en", 32'(ch_en), 32'd0);
      chk("post-reset align busy", 32'(busy), 32'd1);
      tick();
      chk("post-reset first ch_en", 32'(ch_en), 32'b001);
      chk("post-reset first div_clk", 32'(div_clk), 32'b001);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int k = 0; k < 10 && busy; k++) tick();
      chk("post-reset drain busy", 32'(busy), 32'd0);
      chk("post-reset drain div_clk", 32'(div_clk), 32'd0);

      // Maximum ratio 255: pulses exactly 255 cycles apart.
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_ch    = 2'd0;
      cfg_bus.cfg_div   = 8'd255;
      start = 1'b1;
      tick();
      idle_inputs();
      tick();
      chk("max first ch_en", 32'(ch_en), 32'b001);
      gap = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         gap++;
         if (ch_en[0]) break;
      end
      chk("max pulse gap", 32'(gap), 32'd255);
      chk("max div_clk falls", 32'(div_clk), 32'd0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int k = 0; k < 600 && busy; k++) tick();
      chk("max drain busy", 32'(busy), 32'd0);
      chk("max drain div_clk", 32'(div_clk), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
